// File: rtl/lif_neuron_param.sv
// Parametrised leaky integrate-and-fire neuron.
// N-input fan-in, loadable weights, refractory period, clamped membrane.
module lif_neuron_param #(
    parameter int N_IN     = 3,
    parameter int W_W      = 3,
    parameter int V_W      = 5,
    parameter int V_REST   = 6,
    parameter int V_LEAK   = 1,
    parameter int V_THRESH = 14,
    parameter int T_REF    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [N_IN-1:0]                     spikes_in,
    input  logic                                w_we,
    input  logic [(N_IN>1?$clog2(N_IN):1)-1:0]  w_addr,
    input  logic [W_W-1:0]                      w_data,
    output logic                                spike_out,
    output logic [V_W-1:0]                      v_mem,
    output logic                                refractory
);

    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SW = W_W + $clog2(N_IN) + 1;
    localparam int XW = ((V_W > SW) ? V_W : SW) + 2;
    localparam int CW = (T_REF > 1) ? $clog2(T_REF + 1) : 1;

    typedef enum logic {
        ST_INT,
        ST_REF
    } state_t;

    state_t                state_q, state_d;
    logic [V_W-1:0]        v_q, v_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  spk_q, spk_d;
    logic [W_W-1:0]        w_q [N_IN];
    logic [SW-1:0]         sum;
    logic signed [XW-1:0]  v_next;

    // Weight bank: writes are independent of en and state; out-of-range ignored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (rst) begin
                w_q[i] <= '0;
            end else if (w_we && (32'(w_addr) == i)) begin
                w_q[i] <= w_data;
            end
        end
    end

    // Weighted sum of active synapses plus leaky update, in a non-wrapping width.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spikes_in[i]) begin
                sum = sum + SW'(w_q[i]);
            end
        end
        v_next = $signed(XW'(v_q)) + $signed(XW'(sum)) - $signed(XW'(V_LEAK));
    end

    // Next-state logic: integrate/fire/clamp, or count down the refractory window.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        spk_d   = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_INT: begin
                    if (v_next >= $signed(XW'(V_THRESH))) begin
                        v_d   = V_W'(V_REST);
                        spk_d = 1'b1;
                        if (T_REF > 0) begin
                            state_d = ST_REF;
                            cnt_d   = CW'(T_REF);
                        end
                    end else if (v_next < $signed(XW'(V_REST))) begin
                        v_d = V_W'(V_REST);
                    end else begin
                        v_d = v_next[V_W-1:0];
                    end
                end
                ST_REF: begin
                    v_d = V_W'(V_REST);
                    if (cnt_q == CW'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_INT;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = ST_INT;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INT;
            v_q     <= V_W'(V_REST);
            cnt_q   <= '0;
            spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            spk_q   <= spk_d;
        end
    end

    assign spike_out  = spk_q;
    assign v_mem      = v_q;
    assign refractory = (state_q == ST_REF);

endmodule
